// File: rtl/noc_flit_pkg.sv
// Flit format shared by the switch: a two-bit type field above the payload.
package noc_flit_pkg;

   localparam int FLIT_TYPE_W = 2;

   localparam logic [1:0] FLIT_HEAD   = 2'b10;
   localparam logic [1:0] FLIT_BODY   = 2'b00;
   localparam logic [1:0] FLIT_TAIL   = 2'b01;
   localparam logic [1:0] FLIT_SINGLE = 2'b11;

   typedef enum logic {ST_IDLE, ST_LOCKED} alloc_state_t;

   // Full flit width for a given payload width.
   function automatic int flit_width(input int data_width);
      return data_width + FLIT_TYPE_W;
   endfunction

   // Type field occupies the two most significant bits of a flit.
   function automatic int flit_type_hi(input int flit_w);
      return flit_w - 1;
   endfunction

   function automatic int flit_type_lo(input int flit_w);
      return flit_w - FLIT_TYPE_W;
   endfunction

   // A flit ends its packet when it is a TAIL or a SINGLE.
   function automatic logic flit_is_tail(input logic [1:0] ftype);
      return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
   endfunction

   // A flit opens a packet when it is a HEAD or a SINGLE.
   function automatic logic flit_is_head(input logic [1:0] ftype);
      return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
   endfunction

   // Neither opens nor closes a packet.
   function automatic logic flit_is_body(input logic [1:0] ftype);
      return ftype == FLIT_BODY;
   endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker: starts full, saturates at DEPTH.
module credit_counter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             avail_o
);

   logic [CNT_W-1:0] cnt_q;

   // Returned credit and consumed credit in the same cycle cancel out.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CNT_W'(DEPTH);
      end else if (inc_i && !dec_i) begin
         if (cnt_q != CNT_W'(DEPTH)) cnt_q <= cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt_o   = cnt_q;
   assign avail_o = (cnt_q != '0);

endmodule

// File: rtl/output_port_alloc.sv
// Output-port allocation: request gating, grant latch, wormhole lock and
// credit-controlled flit mux onto the output link.
module output_port_alloc
   import noc_flit_pkg::*;
#(
   parameter int IN_N         = 5,
   parameter int DATA_WIDTH   = 8,
   parameter int BUFFER_DEPTH = 4,
   parameter int FLIT_W       = flit_width(DATA_WIDTH),
   parameter int SEL_W        = $clog2(IN_N)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [IN_N-1:0]        in_req_i,
   output logic [IN_N-1:0]        arb_req_o,
   input  logic [SEL_W-1:0]       arb_grant_i,
   input  logic                   arb_grant_vld_i,
   input  logic [IN_N*FLIT_W-1:0] in_flit_i,
   input  logic [IN_N-1:0]        in_vld_i,
   output logic [IN_N-1:0]        in_rdy_o,
   output logic [FLIT_W-1:0]      out_flit_o,
   output logic                   out_vld_o,
   input  logic                   credit_i,
   output logic                   busy_o
);

   localparam int TYPE_HI = flit_type_hi(FLIT_W);
   localparam int TYPE_LO = flit_type_lo(FLIT_W);
   localparam int CNT_W   = $clog2(BUFFER_DEPTH + 1);

   alloc_state_t      state;
   logic [SEL_W-1:0]  sel_q;
   logic [FLIT_W-1:0] cur_flit;
   logic              cur_vld;
   logic              transfer;
   logic              credit_avail;
   logic [CNT_W-1:0]  credit_cnt;

   credit_counter #(
      .DEPTH (BUFFER_DEPTH),
      .CNT_W (CNT_W)
   ) u_credit (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (credit_i),
      .dec_i   (transfer),
      .cnt_o   (credit_cnt),
      .avail_o (credit_avail)
   );

   // Select the locked input's flit/valid and raise only its ready.
   always_comb begin
      cur_flit = '0;
      cur_vld  = 1'b0;
      in_rdy_o = '0;
      for (int i = 0; i < IN_N; i++) begin
         if (sel_q == SEL_W'(i)) begin
            cur_flit    = in_flit_i[i*FLIT_W +: FLIT_W];
            cur_vld     = in_vld_i[i];
            in_rdy_o[i] = (state == ST_LOCKED) && credit_avail;
         end
      end
   end

   // Requests reach the arbiter only while idle with room downstream, so the
   // arbiter's priority state moves only on the cycle a grant is taken.
   assign arb_req_o = (state == ST_IDLE && credit_avail) ? in_req_i : '0;
   assign transfer  = (state == ST_LOCKED) && credit_avail && cur_vld;
   assign busy_o    = (state == ST_LOCKED);

   // Lock FSM with registered output flit; grants while locked are ignored.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         sel_q      <= '0;
         out_vld_o  <= 1'b0;
         out_flit_o <= '0;
      end else begin
         out_vld_o <= transfer;
         if (transfer) out_flit_o <= cur_flit;
         case (state)
            ST_IDLE: begin
               if (arb_grant_vld_i) begin
                  sel_q <= arb_grant_i;
                  state <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (transfer && flit_is_tail(cur_flit[TYPE_HI:TYPE_LO]))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_port_alloc.sv
// Self-checking bench for output_port_alloc with a packet-level reference model.
module tb_output_port_alloc;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  in_req_i;
   logic [4:0]  arb_req_o;
   logic [2:0]  arb_grant_i;
   logic        arb_grant_vld_i;
   logic [49:0] in_flit_i;
   logic [4:0]  in_vld_i;
   logic [4:0]  in_rdy_o;
   logic [9:0]  out_flit_o;
   logic        out_vld_o;
   logic        credit_i;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   // Reference model state: lock owner, credits, last emitted flit.
   bit       m_locked = 0;
   int       m_sel = 0;
   int       m_cred = 4;
   bit       m_xfer;
   logic [4:0] exp_arb_req, exp_in_rdy, obs_arb_req, obs_in_rdy;
   logic       exp_vld, obs_vld, exp_busy, obs_busy;
   logic [9:0] exp_flit = '0, obs_flit;
   logic [2:0] obs_cred;
   int         exp_cred;

   output_port_alloc dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .in_req_i        (in_req_i),
      .arb_req_o       (arb_req_o),
      .arb_grant_i     (arb_grant_i),
      .arb_grant_vld_i (arb_grant_vld_i),
      .in_flit_i       (in_flit_i),
      .in_vld_i        (in_vld_i),
      .in_rdy_o        (in_rdy_o),
      .out_flit_o      (out_flit_o),
      .out_vld_o       (out_vld_o),
      .credit_i        (credit_i),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [9:0] mk(input logic [1:0] t, input logic [7:0] d);
      return {t, d};
   endfunction

   task automatic set_flit(input int k, input logic [9:0] f);
      in_flit_i[k*10 +: 10] = f;
   endtask

   // Drive one cycle, sample combinational outputs mid-cycle, advance the
   // model, then sample registered outputs just after the edge.
   task automatic cycle(input logic r, input logic [4:0] req, input logic gv,
                        input logic [2:0] g, input logic [4:0] vld, input logic cr);
      bit xfer;
      rst_i = r; in_req_i = req; arb_grant_vld_i = gv; arb_grant_i = g;
      in_vld_i = vld; credit_i = cr;
      #1;
      obs_arb_req = arb_req_o;
      obs_in_rdy  = in_rdy_o;
      exp_arb_req = (!m_locked && m_cred != 0) ? req : 5'b0;
      exp_in_rdy  = (m_locked && m_cred != 0) ? 5'(1 << m_sel) : 5'b0;
      xfer = m_locked && (m_cred != 0) && vld[m_sel];
      if (r) begin
         m_locked = 0; m_sel = 0; m_cred = 4; exp_vld = 0; exp_flit = '0; m_xfer = 0;
      end else begin
         m_xfer  = xfer;
         exp_vld = xfer;
         if (m_locked) begin
            if (xfer) begin
               exp_flit = in_flit_i[m_sel*10 +: 10];
               if (exp_flit[8]) m_locked = 0;
            end
         end else if (gv) begin
            m_locked = 1; m_sel = int'(g);
         end
         m_cred = m_cred + int'(cr) - int'(xfer);
         if (m_cred > 4) m_cred = 4;
      end
      exp_busy = m_locked;
      exp_cred = m_cred;
      @(posedge clk_i); #1;
      obs_vld  = out_vld_o;
      obs_flit = out_flit_o;
      obs_busy = busy_o;
      obs_cred = dut.credit_cnt;
   endtask

   task automatic test_reset();
      in_flit_i = '0;
      cycle(1'b1, 5'b0, 1'b0, 3'd0, 5'b0, 1'b0);
      checks++;
      if (obs_vld !== 1'b0 || obs_flit !== 10'h0 || obs_busy !== 1'b0 || obs_cred !== 3'd4) begin
         errors++;
         $display("FAIL reset_regs got vld=%b flit=%h busy=%b cred=%0d want 0 000 0 4",
                  obs_vld, obs_flit, obs_busy, obs_cred);
      end
      cycle(1'b1, 5'b0, 1'b0, 3'd0, 5'b0, 1'b0);
      checks++;
      if (obs_arb_req !== 5'b0 || obs_in_rdy !== 5'b0) begin
         errors++;
         $display("FAIL reset_comb got arb_req=%b in_rdy=%b want 00000 00000", obs_arb_req, obs_in_rdy);
      end
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b0, 1'b0);
   endtask

   task automatic test_packet3();
      logic [9:0] pkt [3];
      int idx = 0;
      pkt[0] = mk(2'b10, 8'hA1); pkt[1] = mk(2'b00, 8'hB2); pkt[2] = mk(2'b01, 8'hC3);
      cycle(1'b0, 5'b00110, 1'b1, 3'd2, 5'b0, 1'b0);
      checks++;
      if (obs_arb_req !== 5'b00110 || obs_busy !== 1'b1) begin
         errors++;
         $display("FAIL pkt3_grant got arb_req=%b busy=%b want 00110 1", obs_arb_req, obs_busy);
      end
      for (int c = 0; c < 10 && idx < 3; c++) begin
         set_flit(2, pkt[idx]);
         cycle(1'b0, 5'b00110, 1'b0, 3'd0, 5'b00100, 1'b0);
         checks++;
         if ({obs_arb_req, obs_in_rdy} !== {exp_arb_req, exp_in_rdy}) begin
            errors++;
            $display("FAIL pkt3_comb got %b/%b want %b/%b", obs_arb_req, obs_in_rdy, exp_arb_req, exp_in_rdy);
         end
         checks++;
         if ({obs_vld, obs_flit} !== {1'b1, pkt[idx]}) begin
            errors++;
            $display("FAIL pkt3_flit%0d got vld=%b flit=%h want 1 %h", idx, obs_vld, obs_flit, pkt[idx]);
         end
         if (m_xfer) idx++;
      end
      checks++;
      if (idx != 3 || obs_busy !== 1'b0) begin
         errors++;
         $display("FAIL pkt3_done got flits=%0d busy=%b want 3 0", idx, obs_busy);
      end
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b0, 1'b0);
      checks++;
      if (obs_vld !== 1'b0) begin
         errors++;
         $display("FAIL pkt3_after got vld=%b want 0", obs_vld);
      end
   endtask

   task automatic test_single();
      int pulses = 0;
      cycle(1'b0, 5'b00001, 1'b1, 3'd0, 5'b0, 1'b0);
      set_flit(0, mk(2'b11, 8'h5A));
      for (int c = 0; c < 4; c++) begin
         cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00001, 1'b1);
         if (obs_vld === 1'b1) pulses++;
         checks++;
         if ({obs_vld, obs_flit, obs_busy} !== {exp_vld, exp_flit, exp_busy}) begin
            errors++;
            $display("FAIL single_c%0d got %b %h %b want %b %h %b", c, obs_vld, obs_flit, obs_busy,
                     exp_vld, exp_flit, exp_busy);
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL single_pulses got %0d want 1", pulses);
      end
   endtask

   task automatic test_credit_stall();
      int idx = 0, n = 0;
      logic [9:0] pkt [6];
      for (int i = 0; i < 6; i++) pkt[i] = mk(i == 0 ? 2'b10 : (i == 5 ? 2'b01 : 2'b00), 8'(8'h10 + i));
      cycle(1'b0, 5'b00100, 1'b1, 3'd2, 5'b0, 1'b0);
      for (int c = 0; c < 7; c++) begin
         set_flit(2, pkt[idx]);
         cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00100, 1'b0);
         if (m_xfer) idx++;
         checks++;
         if ({obs_vld, obs_flit, obs_cred} !== {exp_vld, exp_flit, 3'(exp_cred)}) begin
            errors++;
            $display("FAIL stall_c%0d got %b %h %0d want %b %h %0d", c, obs_vld, obs_flit, obs_cred,
                     exp_vld, exp_flit, exp_cred);
         end
      end
      checks++;
      if (idx != 4 || obs_in_rdy !== 5'b0 || obs_vld !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold got flits=%0d in_rdy=%b vld=%b want 4 00000 0", idx, obs_in_rdy, obs_vld);
      end
      set_flit(2, pkt[idx]);
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00100, 1'b1);
      for (int c = 0; c < 3; c++) begin
         set_flit(2, pkt[idx]);
         cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00100, 1'b0);
         if (m_xfer) idx++;
         if (obs_vld === 1'b1) n++;
         checks++;
         if (c == 0 && {obs_vld, obs_flit} !== {1'b1, pkt[4]}) begin
            errors++;
            $display("FAIL stall_credit got vld=%b flit=%h want 1 %h", obs_vld, obs_flit, pkt[4]);
         end
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL stall_one_more got %0d want 1", n);
      end
      for (int c = 0; c < 6 && idx < 6; c++) begin
         set_flit(2, pkt[idx]);
         cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00100, 1'b1);
         if (m_xfer) idx++;
      end
      checks++;
      if (idx != 6 || obs_busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_finish got flits=%0d busy=%b want 6 0", idx, obs_busy);
      end
      for (int c = 0; c < 4; c++) cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b0, 1'b1);
   endtask

   task automatic test_credit_coincident();
      cycle(1'b0, 5'b00010, 1'b1, 3'd1, 5'b0, 1'b0);
      set_flit(1, mk(2'b10, 8'h21));
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
      set_flit(1, mk(2'b00, 8'h22));
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
      checks++;
      if (obs_cred !== 3'd2) begin
         errors++;
         $display("FAIL coinc_pre got cred=%0d want 2", obs_cred);
      end
      set_flit(1, mk(2'b00, 8'h23));
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b1);
      checks++;
      if (obs_cred !== 3'd2 || obs_vld !== 1'b1) begin
         errors++;
         $display("FAIL coinc_both got cred=%0d vld=%b want 2 1", obs_cred, obs_vld);
      end
      set_flit(1, mk(2'b01, 8'h24));
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
      for (int c = 0; c < 5; c++) cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b0, 1'b1);
      checks++;
      if (obs_cred !== 3'd4 || obs_busy !== 1'b0) begin
         errors++;
         $display("FAIL coinc_sat got cred=%0d busy=%b want 4 0", obs_cred, obs_busy);
      end
   endtask

   task automatic test_reset_midpacket();
      int idx = 0;
      cycle(1'b0, 5'b00010, 1'b1, 3'd1, 5'b0, 1'b0);
      set_flit(1, mk(2'b10, 8'h31));
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
      set_flit(1, mk(2'b00, 8'h32));
      cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
      cycle(1'b1, 5'b0, 1'b0, 3'd0, 5'b00010, 1'b0);
      checks++;
      if (obs_busy !== 1'b0 || obs_cred !== 3'd4 || obs_vld !== 1'b0) begin
         errors++;
         $display("FAIL midrst got busy=%b cred=%0d vld=%b want 0 4 0", obs_busy, obs_cred, obs_vld);
      end
      cycle(1'b0, 5'b01000, 1'b1, 3'd3, 5'b0, 1'b0);
      for (int c = 0; c < 6 && idx < 2; c++) begin
         set_flit(3, idx == 0 ? mk(2'b10, 8'h41) : mk(2'b01, 8'h42));
         cycle(1'b0, 5'b0, 1'b0, 3'd0, 5'b01000, 1'b0);
         checks++;
         if ({obs_vld, obs_flit, obs_in_rdy} !== {exp_vld, exp_flit, exp_in_rdy}) begin
            errors++;
            $display("FAIL midrst_new got %b %h %b want %b %h %b", obs_vld, obs_flit, obs_in_rdy,
                     exp_vld, exp_flit, exp_in_rdy);
         end
         if (m_xfer) idx++;
      end
      checks++;
      if (idx != 2 || obs_flit !== mk(2'b01, 8'h42)) begin
         errors++;
         $display("FAIL midrst_done got flits=%0d flit=%h want 2 142", idx, obs_flit);
      end
   endtask

   task automatic test_random();
      logic gv;
      for (int c = 0; c < 400; c++) begin
         in_flit_i = 50'({$urandom(), $urandom()});
         gv = !m_locked && ($urandom_range(2) == 0);
         cycle($urandom_range(99) == 0, 5'($urandom()), gv, 3'($urandom_range(4)),
               5'($urandom()), $urandom_range(2) == 0);
         checks++;
         if ({obs_arb_req, obs_in_rdy} !== {exp_arb_req, exp_in_rdy}) begin
            errors++;
            $display("FAIL rand_comb c%0d got %b/%b want %b/%b", c, obs_arb_req, obs_in_rdy,
                     exp_arb_req, exp_in_rdy);
         end
         checks++;
         if ({obs_vld, obs_flit} !== {exp_vld, exp_flit}) begin
            errors++;
            $display("FAIL rand_out c%0d got %b %h want %b %h", c, obs_vld, obs_flit, exp_vld, exp_flit);
         end
         checks++;
         if ({obs_busy, obs_cred} !== {exp_busy, 3'(exp_cred)}) begin
            errors++;
            $display("FAIL rand_state c%0d got busy=%b cred=%0d want %b %0d", c, obs_busy, obs_cred,
                     exp_busy, exp_cred);
         end
      end
   endtask

   initial begin
      test_reset();
      test_packet3();
      test_single();
      test_credit_stall();
      test_credit_coincident();
      test_reset_midpacket();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/output_port_alloc.md
# output_port_alloc

Output-port allocation stage of the NoC switch, sitting directly downstream of the per-output matrix arbiter. It gates input-port requests into the arbiter and latches the arbiter's grant. It then holds a wormhole lock on the winning input until that input's tail flit has passed, muxing the granted input's flits onto the output link under credit-based flow control. One instance per switch output port.

## Interface
- IN_N, 5: number of switch inputs competing for this output.
- DATA_WIDTH, 8: flit payload width; flit width FLIT_W = DATA_WIDTH+2.
- BUFFER_DEPTH, 4: downstream input-buffer depth; initial credit count.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_req_i  in  IN_N  bit i: input i holds a head flit routed to this output.
- arb_req_o  out  IN_N  requests to arbiter req_i.
- arb_grant_i  in  $clog2(IN_N)  arbiter winner index.
- arb_grant_vld_i  in  1  arbiter winner valid.
- in_flit_i  in  IN_N*FLIT_W  flattened flits; input i at [i*FLIT_W +: FLIT_W].
- in_vld_i  in  IN_N  flit valid per input.
- in_rdy_o  out  IN_N  flit accepted per input (one-hot or zero).
- out_flit_o  out  FLIT_W  registered output flit.
- out_vld_o  out  1  registered output valid.
- credit_i  in  1  one downstream buffer slot freed this cycle.
- busy_o  out  1  high while locked to an input.

## Operation
- Flit type in bits [FLIT_W-1:FLIT_W-2]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE (head+tail).
- FSM states: IDLE, LOCKED. Reset state: IDLE.
- IDLE:
  - arb_req_o = in_req_i when credit_cnt != 0, else 0.
  - in_rdy_o = 0.
  - On arb_grant_vld_i: sel_q <= arb_grant_i; go LOCKED.
- LOCKED:
  - arb_req_o = 0. This is mandatory, so the arbiter's priority matrix only updates on the cycle a grant is taken.
  - in_rdy_o[sel_q] = (credit_cnt != 0); all other in_rdy_o bits are 0.
  - Transfer = in_vld_i[sel_q] & in_rdy_o[sel_q].
  - On transfer: out_flit_o <= in_flit_i[sel_q]; out_vld_o <= 1.
  - On transfer of TAIL or SINGLE: go IDLE. On HEAD or BODY: stay LOCKED.
- out_vld_o <= 0 on any cycle without a transfer. out_flit_o holds its last value.
- Credit counter, width $clog2(BUFFER_DEPTH+1), reset value BUFFER_DEPTH:
  - transfer only: -1.
  - credit_i only: +1, saturating at BUFFER_DEPTH.
  - both in the same cycle: unchanged.
- Never underflows: in_rdy_o is gated by credit_cnt != 0.
- Flit type is not checked for ordering beyond tail detection. The upstream input buffer guarantees the first flit after a grant is HEAD or SINGLE.

## Timing
- Reset values: arb_req_o=0, in_rdy_o=0, out_vld_o=0, out_flit_o=0, busy_o=0, sel_q=0, credit_cnt=BUFFER_DEPTH, state IDLE.
- arb_req_o, in_rdy_o: combinational from state, credit_cnt, in_req_i.
- busy_o: equals (state == LOCKED).
- Grant sampled at edge N → LOCKED from cycle N+1 → first flit accepted in N+1 at the earliest → visible on out_flit_o/out_vld_o in N+2.
- Tail accepted at edge M → IDLE in M+1 → a new arbitration request is possible in M+1, giving a 1-cycle bubble between packets.
- Throughput: 1 flit/cycle while credits are available.
- credit_i arriving in the cycle the counter is at 0 enables in_rdy_o the following cycle. There is no same-cycle bypass.
- rst_i mid-packet: the lock is dropped, credits are restored, out_vld_o=0 next cycle. The rest of the switch is reset simultaneously.
- arb_grant_vld_i while LOCKED cannot occur because arb_req_o=0. It is ignored if it does.

## Structure
- Shared package/header noc_flit_pkg:
  - flit type localparams (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE);
  - FLIT_W derivation;
  - type-field bit positions.
- One sub-module: credit_counter (parameter DEPTH; ports inc_i, dec_i, cnt_o, avail_o), reused by other output ports and by link-level stages.
- The flit mux is inline; there is no separate crossbar module.

## Test plan
- Reset → arb_req_o=0, out_vld_o=0, busy_o=0, credit_cnt=4.
- IDLE, in_req_i=5'b00110, grant=2 valid → arb_req_o drops to 0 next cycle, busy_o=1. A 3-flit packet HEAD/BODY/TAIL on input 2 appears on out_flit_o in consecutive cycles, each one cycle after acceptance. IDLE follows the TAIL.
- SINGLE flit on input 0 after grant → exactly one out_vld_o pulse, back to IDLE one cycle after acceptance.
- 6-flit packet with no credit_i → 4 flits pass, then in_rdy_o[sel]=0 with out_vld_o=0. One credit_i pulse → exactly one more flit, one cycle later.
- credit_i coincident with a transfer at credit_cnt=2 → count stays 2. credit_i with credit_cnt=4 → stays 4.
- rst_i asserted after the 2nd flit of a 4-flit packet → next cycle IDLE, busy_o=0, credit_cnt=4. A new grant on input 3 is served normally.
